// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: segment codes and scan FSM encoding for the BCD display scanner.
package bcd_disp_pkg;
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    typedef enum logic {IDLE, SCAN} state_t;
endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: one BCD digit to active-high segments; non-decimal nibbles show a dash.
module bcd_to_7seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    output logic [6:0] o_seg
);
    logic [6:0] w_seg;

    always_comb begin
        case (i_digit)
            4'd0:    w_seg = SEG_0;
            4'd1:    w_seg = SEG_1;
            4'd2:    w_seg = SEG_2;
            4'd3:    w_seg = SEG_3;
            4'd4:    w_seg = SEG_4;
            4'd5:    w_seg = SEG_5;
            4'd6:    w_seg = SEG_6;
            4'd7:    w_seg = SEG_7;
            4'd8:    w_seg = SEG_8;
            4'd9:    w_seg = SEG_9;
            default: w_seg = SEG_DASH;
        endcase
    end

    assign o_seg = i_blank ? SEG_OFF : w_seg;
endmodule

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: captures a packed BCD word on load and scans its digits
// one at a time onto a common-bus seven-segment display.
module bcd_display_scanner
    import bcd_disp_pkg::*;
#(
    parameter int D        = 3,
    parameter int PRESCALE = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [4*D-1:0] bcd,
    input  logic           blank_lz,
    output logic [6:0]     seg,
    output logic [D-1:0]   an,
    output logic           err,
    output logic           active
);
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    state_t         r_state, w_state_nxt;
    logic [4*D-1:0] r_held;
    logic [IW-1:0]  r_idx;
    logic [PW-1:0]  r_pcnt;
    logic           r_err;
    logic           r_blank_lz;
    logic           w_bad;
    logic [4*D-1:0] w_shifted;
    logic           w_blank;
    logic [6:0]     w_seg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = load ? SCAN : r_state;
    end

    always_comb begin
        w_bad = 1'b0;
        for (int k = 0; k < D; k++) w_bad = w_bad | (bcd[4*k +: 4] > 4'd9);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_held     <= '0;
            r_idx      <= '0;
            r_pcnt     <= '0;
            r_err      <= 1'b0;
            r_blank_lz <= 1'b0;
        end else begin
            r_blank_lz <= blank_lz;
            if (load) begin
                r_held <= bcd;
                r_idx  <= '0;
                r_pcnt <= '0;
                r_err  <= w_bad;
            end else if (r_state == SCAN) begin
                if (r_pcnt == PW'(PRESCALE - 1)) begin
                    r_pcnt <= '0;
                    r_idx  <= (r_idx == IW'(D - 1)) ? '0 : r_idx + IW'(1);
                end else begin
                    r_pcnt <= r_pcnt + PW'(1);
                end
            end
        end
    end

    // Shifting the held word down by the scan index leaves exactly digits idx..D-1,
    // so the low nibble is the shown digit and a zero result means it is a leading zero.
    assign w_shifted = r_held >> {r_idx, 2'b00};
    assign w_blank   = r_blank_lz && (r_idx != '0) && (w_shifted == '0);

    bcd_to_7seg u_dec (
        .i_digit (w_shifted[3:0]),
        .i_blank (w_blank),
        .o_seg   (w_seg)
    );

    assign active = (r_state == SCAN);
    assign seg    = active ? w_seg : SEG_OFF;
    assign an     = active ? (D'(1) << r_idx) : '0;
    assign err    = r_err;
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: directed and randomized checks against a frame-position model.
module tb_bcd_display_scanner;
    localparam int D = 3;
    localparam int P = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           load = 1'b0;
    logic [4*D-1:0] bcd = '0;
    logic           blank_lz = 1'b0;
    logic [6:0]     seg;
    logic [D-1:0]   an;
    logic           err;
    logic           active;

    int checks = 0;
    int errors = 0;

    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    // model: captured digits, cycles since capture, and the registered blanking mode
    int m_dig [D];
    int m_t = 0;
    bit m_active = 0;
    bit m_err = 0;
    bit m_blz = 0;

    always #5 clk = ~clk;

    bcd_display_scanner #(.D(D), .PRESCALE(P)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .bcd      (bcd),
        .blank_lz (blank_lz),
        .seg      (seg),
        .an       (an),
        .err      (err),
        .active   (active)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_idx();
        return (m_t / P) % D;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < D; k++) m_dig[k] = 0;
        m_t = 0; m_active = 0; m_err = 0; m_blz = 0;
    endtask

    task automatic check_outputs(input string tag);
        int i;
        bit lead;
        logic [6:0] es;
        logic [D-1:0] ea;
        i = m_idx();
        lead = (i > 0);
        for (int k = i; k < D; k++) if (m_dig[k] != 0) lead = 0;
        es = !m_active ? 7'h00 : (m_blz && lead) ? 7'h00 : tbl[m_dig[i]];
        ea = m_active ? D'(1 << i) : '0;
        check({tag, ".seg"}, 32'(seg), 32'(es));
        check({tag, ".an"}, 32'(an), 32'(ea));
        check({tag, ".err"}, 32'(err), 32'(m_err));
        check({tag, ".active"}, 32'(active), 32'(m_active));
    endtask

    // apply inputs for one clock, advance the model, check at the falling edge
    task automatic step(input string tag, input bit ld, input logic [4*D-1:0] b, input bit blz);
        load = ld; bcd = b; blank_lz = blz;
        @(posedge clk);
        m_blz = blz;
        if (ld) begin
            m_err = 0;
            for (int k = 0; k < D; k++) begin
                m_dig[k] = int'((b >> (4 * k)) & 12'hF);
                if (m_dig[k] > 9) m_err = 1;
            end
            m_t = 0;
            m_active = 1;
        end else if (m_active) begin
            m_t = (m_t + 1) % (D * P);
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic async_reset(input string tag);
        @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1 check_outputs(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [4*D-1:0] rb;
    bit rblz;

    initial begin
        model_reset();
        #12 rst = 1'b0;
        @(negedge clk);
        check_outputs("reset");
        for (int n = 0; n < 20; n++) step("idle", 0, '0, 0);

        step("load042", 1, 12'h042, 0);
        for (int n = 0; n < 13; n++) step("scan042", 0, '0, 0);

        step("lz042", 1, 12'h042, 1);
        for (int n = 0; n < D * P; n++) step("lz042", 0, '0, 1);
        step("lz000", 1, 12'h000, 1);
        for (int n = 0; n < D * P; n++) step("lz000", 0, '0, 1);
        step("lz102", 1, 12'h102, 1);
        for (int n = 0; n < D * P; n++) step("lz102", 0, '0, 1);

        step("bad04C", 1, 12'h04C, 0);
        for (int n = 0; n < 6; n++) step("bad04C", 0, '0, 0);
        step("ok049", 1, 12'h049, 0);
        for (int n = 0; n < 3; n++) step("ok049", 0, '0, 0);

        while (m_idx() != 2) step("seek", 0, '0, 0);
        step("midscan", 0, '0, 0);
        step("reload", 1, 12'h049, 0);
        for (int n = 0; n < P + 1; n++) step("reload", 0, '0, 0);
        for (int n = 0; n < 10; n++) step("hold", 1, 12'h049, 0);

        async_reset("midreset");
        for (int n = 0; n < 5; n++) step("postreset", 0, '0, 0);

        rblz = 0;
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < D; k++)
                rb[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 40) == 0) rblz = ~rblz;
            step("rand", $urandom_range(0, 15) == 0, rb, rblz);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
